// File: rtl/counter_checker_pkg.sv
// Shared types and helpers for the counter checker: FSM state encoding and
// the saturating increment used by the error/check counters.
package counter_checker_pkg;

    typedef enum logic [1:0] {SYNC, CHECK, FAIL} chk_state_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Golden N-bit up/down counter with load, tracking the same control inputs as
// the counter under check; also produces the expected threshold.
module counter_ref_model
    import counter_checker_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         dec,
    input  logic         load,
    input  logic [N-1:0] load_ref_value,
    output logic [N-1:0] model,
    output logic         thr_exp
);

    // Priority: load over enable; arithmetic wraps modulo 2^N.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            model <= '0;
        end else if (clear) begin
            model <= '0;
        end else if (load) begin
            model <= load_ref_value;
        end else if (enable) begin
            model <= dec ? model - 1'b1 : model + 1'b1;
        end
    end

    assign thr_exp = (model >= load_ref_value);

endmodule

// File: rtl/counter_checker.sv
// Observer that compares a counter's outputs against a golden model every cycle,
// latching the first failure. Optional capture of the first failing values is
// enabled by defining COUNTER_CHECKER_CAPTURE_EN.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic          dec,
    input  logic          load,
    input  logic [N-1:0]  load_ref_value,
    input  logic [N-1:0]  counterN,
    input  logic          threshold,
    output logic          mismatch,
    output logic          error_sticky,
    output logic [CW-1:0] error_count,
    output logic [CW-1:0] check_count,
    output logic [N-1:0]  first_err_got,
    output logic [N-1:0]  first_err_exp
);

    chk_state_t   state_reg, state_next;
    logic [N-1:0] model;
    logic         thr_exp;
    logic         do_check;
    logic         miss;

    counter_ref_model #(.N(N)) u_model (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear),
        .enable         (enable),
        .dec            (dec),
        .load           (load),
        .load_ref_value (load_ref_value),
        .model          (model),
        .thr_exp        (thr_exp)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_check   = 1'b0;
        miss       = 1'b0;
        case (state_reg)
            SYNC:  state_next = CHECK;
            CHECK: begin
                do_check = 1'b1;
                miss     = (counterN != model) || (threshold != thr_exp);
                if (miss) begin
                    state_next = FAIL;
                end
            end
            FAIL:    state_next = FAIL;
            default: state_next = SYNC;
        endcase
        // clear overrides whatever the comparison found on this edge
        if (clear) begin
            state_next = SYNC;
            do_check   = 1'b0;
            miss       = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mismatch     <= 1'b0;
            error_sticky <= 1'b0;
            error_count  <= '0;
            check_count  <= '0;
        end else if (clear) begin
            mismatch     <= 1'b0;
            error_sticky <= 1'b0;
            error_count  <= '0;
            check_count  <= '0;
        end else begin
            mismatch <= miss;
            if (miss) begin
                error_sticky <= 1'b1;
                error_count  <= CW'(sat_inc(32'(error_count), unsigned'(CW)));
            end
            if (do_check) begin
                check_count <= CW'(sat_inc(32'(check_count), unsigned'(CW)));
            end
        end
    end

`ifdef COUNTER_CHECKER_CAPTURE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (clear) begin
            first_err_got <= '0;
            first_err_exp <= '0;
        end else if (miss && !error_sticky) begin
            first_err_got <= counterN;
            first_err_exp <= model;
        end
    end
`else
    assign first_err_got = '0;
    assign first_err_exp = '0;
`endif

endmodule
